fp_addsub_p: RTL and testbench

Parametrised, IEEE-754-style floating-point add/subtract unit. It is the next-generation replacement for the single-precision add/sub engine. Exponent and fraction widths are configurable. It adds full guard/round/sticky alignment, round-to-nearest-even, special-value handling, exception flags and a valid/ready handshake on both sides. It sits between the FPU operand issue logic and the result writeback mux.

---
 rtl/fp_addsub_p_if.sv | 28 ++
 rtl/fp_addsub_p.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_p.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_p_if.sv
// Operand-issue and result-writeback handshake bundle for the FP add/sub unit.
// master drives operands and out_ready; slave is the arithmetic unit.
interface fp_addsub_p_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_addsub_p.sv
// Parametrised IEEE-754 add/subtract with GRS alignment, RNE rounding, specials and flags.
// Fixed 5-edge accept-to-valid latency, one op in flight; out_ready low holds the result.
module fp_addsub_p #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_addsub_p_if.slave io
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_ADDSUB = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0] EXP_INF = {2'b00, {EXP_W{1'b1}}};

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
  } fp_t;

  logic [2:0]       state;
  logic             astep;
  fp_t              opa, opb;
  logic             sub_q;
  logic             in_ready_q, out_valid_q;
  logic [W-1:0]     result_q;
  logic [3:0]       flags_q;
  logic             spec_q, spec_inv_q;
  logic [W-1:0]     spec_res_q;
  logic             big_s, sml_s;
  logic [EXP_W-1:0] big_e, sml_e;
  logic [MAN_W:0]   big_m, sml_m;
  logic [MW-1:0]    sml_al;
  logic [MW:0]      sum_q;
  logic             zero_q, zero_s_q;
  logic [MW-1:0]    norm_m;
  logic [XW-1:0]    exp_q;

  // Classification and magnitude swap
  logic         sb, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
  logic         dec_spec, dec_inv;
  logic [W-1:0] dec_res;

  always_comb begin
    sb     = opb.s ^ sub_q;
    a_nan  = (&opa.e) && (|opa.f);
    b_nan  = (&opb.e) && (|opb.f);
    a_inf  = (&opa.e) && !(|opa.f);
    b_inf  = (&opb.e) && !(|opb.f);
    a_snan = a_nan && !opa.f[MAN_W-1];
    b_snan = b_nan && !opb.f[MAN_W-1];
    swap   = {opb.e, opb.f} > {opa.e, opa.f};
    dec_spec = 1'b0;
    dec_inv  = 1'b0;
    dec_res  = '0;
    if (a_nan || b_nan) begin
      dec_spec = 1'b1;
      dec_res  = QNAN;
      dec_inv  = a_snan || b_snan;
    end else if (a_inf && b_inf && (opa.s != sb)) begin
      dec_spec = 1'b1;
      dec_res  = QNAN;
      dec_inv  = 1'b1;
    end else if (a_inf) begin
      dec_spec = 1'b1;
      dec_res  = opa;
    end else if (b_inf) begin
      dec_spec = 1'b1;
      dec_res  = {sb, opb.e, opb.f};
    end
  end

  // Alignment shift of the smaller operand; dropped bits fold into S
  logic [EXP_W-1:0] d_sh;
  logic [MW-1:0]    sml_ext, al;
  logic             st;

  always_comb begin
    d_sh    = big_e - sml_e;
    sml_ext = {sml_m, 3'b000};
    st      = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (i < int'(d_sh)) st = st | sml_ext[i];
    end
    if (int'(d_sh) >= MW) al = {{(MW-1){1'b0}}, |sml_m};
    else                  al = (sml_ext >> d_sh) | {{(MW-1){1'b0}}, st};
  end

  logic        eff_add;
  logic [MW:0] sum;

  always_comb begin
    eff_add = (big_s == sml_s);
    if (eff_add) sum = {1'b0, big_m, 3'b000} + {1'b0, sml_al};
    else         sum = {1'b0, big_m, 3'b000} - {1'b0, sml_al};
  end

  // Normalisation: left shift is capped so the exponent never drops below 1
  int            lz, lim, sh;
  logic          found;
  logic [MW-1:0] nm;
  logic [XW-1:0] ne;

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_q[i]) found = 1'b1;
        else          lz = lz + 1;
      end
    end
    lim = int'(exp_q) - 1;
    sh  = (lz < lim) ? lz : lim;
    if (sum_q[MW]) begin
      nm = {sum_q[MW:2], |sum_q[1:0]};
      ne = exp_q + XW'(1);
    end else begin
      nm = sum_q[MW-1:0] << sh;
      ne = exp_q - XW'(sh);
    end
  end

  logic             g, r, s_b, inx, inc;
  logic [MAN_W+1:0] mant;
  logic [MAN_W:0]   mant2;
  logic [XW-1:0]    re;
  logic [W-1:0]     rres;
  logic [3:0]       rfl;

  always_comb begin
    g    = norm_m[2];
    r    = norm_m[1];
    s_b  = norm_m[0];
    inx  = g | r | s_b;
    inc  = g & (r | s_b | norm_m[3]);
    mant = {1'b0, norm_m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (mant[MAN_W+1]) begin
      mant2 = mant[MAN_W+1:1];
      re    = exp_q + XW'(1);
    end else begin
      mant2 = mant[MAN_W:0];
      re    = exp_q;
    end
    rres = '0;
    rfl  = '0;
    if (spec_q) begin
      rres = spec_res_q;
      rfl  = {spec_inv_q, 3'b000};
    end else if (zero_q) begin
      rres = {zero_s_q, {(W-1){1'b0}}};
    end else if (re >= EXP_INF) begin
      rres = {big_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rfl  = 4'b0101;
    end else begin
      // Hidden bit clear means the value stayed subnormal: exponent field 0
      rres = {big_s, (mant2[MAN_W] ? re[EXP_W-1:0] : {EXP_W{1'b0}}), mant2[MAN_W-1:0]};
      rfl  = {2'b00, ~mant2[MAN_W] & inx, inx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      astep       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_res_q  <= '0;
      big_s       <= 1'b0;
      sml_s       <= 1'b0;
      big_e       <= '0;
      sml_e       <= '0;
      big_m       <= '0;
      sml_m       <= '0;
      sml_al      <= '0;
      sum_q       <= '0;
      zero_q      <= 1'b0;
      zero_s_q    <= 1'b0;
      norm_m      <= '0;
      exp_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (io.in_valid && in_ready_q) begin
            opa        <= io.a;
            opb        <= io.b;
            sub_q      <= io.op_sub;
            astep      <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= S_ALIGN;
          end
        end
        // ALIGN spans two cycles: classify/swap, then the alignment shift
        S_ALIGN: begin
          if (!astep) begin
            spec_q     <= dec_spec;
            spec_inv_q <= dec_inv;
            spec_res_q <= dec_res;
            big_s      <= swap ? sb : opa.s;
            sml_s      <= swap ? opa.s : sb;
            big_e      <= swap ? ((opb.e == '0) ? EXP_W'(1) : opb.e)
                               : ((opa.e == '0) ? EXP_W'(1) : opa.e);
            sml_e      <= swap ? ((opa.e == '0) ? EXP_W'(1) : opa.e)
                               : ((opb.e == '0) ? EXP_W'(1) : opb.e);
            big_m      <= swap ? {|opb.e, opb.f} : {|opa.e, opa.f};
            sml_m      <= swap ? {|opa.e, opa.f} : {|opb.e, opb.f};
            astep      <= 1'b1;
          end else begin
            sml_al <= al;
            exp_q  <= {2'b00, big_e};
            astep  <= 1'b0;
            state  <= S_ADDSUB;
          end
        end
        S_ADDSUB: begin
          sum_q    <= sum;
          zero_q   <= (sum == '0);
          zero_s_q <= eff_add & big_s;
          state    <= S_NORM;
        end
        S_NORM: begin
          norm_m <= nm;
          exp_q  <= ne;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          result_q    <= rres;
          flags_q     <= rfl;
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_p.sv
// Directed vector bench for fp_addsub_p at single precision, plus backpressure and mid-op reset.
module tb_fp_addsub_p;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_addsub_p_if #(.EXP_W(8), .MAN_W(23)) io ();

  fp_addsub_p #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
    int n = 0;
    while (!io.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!io.in_ready) check("in_ready_wait", io.in_ready, 1);
    io.a        = xa;
    io.b        = xb;
    io.op_sub   = xs;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (io.out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, 5);
  endtask

  task automatic take(input string name);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    check({name, "_valid_drop"}, io.out_valid, 0);
    check({name, "_ready_back"}, io.in_ready, 1);
    check({name, "_flags_clr"}, io.flags, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic saw;
    string nm;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
    vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
    vecs[2]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
    vecs[5]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0};
    vecs[6]  = '{32'h00800000, 32'h007FFFFF, 1'b1, 32'h00000001, 4'h0};
    vecs[7]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
    vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0};
    vecs[10] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'h0};
    vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
    vecs[12] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
    vecs[13] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'h0};
    vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'h0};
    vecs[15] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};
    vecs[16] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1};
    vecs[17] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'h0};

    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.op_sub    = 1'b0;
    io.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", io.in_ready, 0);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_result", io.result, 0);
    check("rst_flags", io.flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", io.in_ready, 1);
    check("idle_out_valid", io.out_valid, 0);

    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      send(vecs[i].a, vecs[i].b, vecs[i].sub);
      check({nm, "_busy"}, io.in_ready, 0);
      wait_out(nm, lat);
      check({nm, "_result"}, io.result, vecs[i].res);
      check({nm, "_flags"}, io.flags, {28'd0, vecs[i].fl});
      take(nm);
    end

    // Backpressure: hold OUT for 10 cycles while poking in_valid
    send(32'h3F800000, 32'h3F800000, 1'b0);
    wait_out("bp", lat);
    for (int i = 0; i < 10; i++) begin
      io.in_valid = (i % 2 == 0);
      io.a        = 32'h7F800000;
      io.b        = 32'h7F800000;
      io.op_sub   = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", i), io.out_valid, 1);
      check($sformatf("bp_hold%0d_result", i), io.result, 32'h40000000);
      check($sformatf("bp_hold%0d_flags", i), io.flags, 0);
      check($sformatf("bp_hold%0d_in_ready", i), io.in_ready, 0);
    end
    io.in_valid = 1'b0;
    take("bp");
    send(32'h40400000, 32'h3F800000, 1'b1);
    check("b2b_accepted", io.in_ready, 0);
    wait_out("b2b", lat);
    check("b2b_result", io.result, 32'h40000000);
    check("b2b_flags", io.flags, 0);
    take("b2b");

    // Reset while the operation sits in NORM
    send(32'h3F800000, 32'h3F800000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", io.out_valid, 0);
    check("mid_rst_result", io.result, 0);
    check("mid_rst_flags", io.flags, 0);
    check("mid_rst_in_ready", io.in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (io.out_valid) saw = 1'b1;
    end
    check("mid_rst_no_valid", saw, 0);
    check("mid_rst_result_idle", io.result, 0);
    send(32'h40400000, 32'h3F800000, 1'b1);
    wait_out("post_rst", lat);
    check("post_rst_result", io.result, 32'h40000000);
    check("post_rst_flags", io.flags, 0);
    take("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
